// File: rtl/obm_dma_if.sv
// Shared types for the mapache64 video path and the OBM DMA bus interface.
// The master modport is the DMA engine; the slave modport is the CPU/memory/VRAM side.
package mapache64;
  typedef logic [11:0] vram_address_t;
  typedef logic [7:0]  data_t;
endpackage

interface obm_dma_if;
  logic                    start_i;
  logic [7:0]              src_page_i;
  logic                    vblank_i;
  logic [15:0]             mem_address_o;
  logic                    mem_ren_o;
  logic [7:0]              mem_rdata_i;
  mapache64::vram_address_t vram_address_o;
  mapache64::data_t        vram_wdata_o;
  logic                    vram_wen_o;
  logic                    SELECT_obm_o;
  logic                    busy_o;
  logic                    done_o;

  modport master (
    input  start_i, src_page_i, vblank_i, mem_rdata_i,
    output mem_address_o, mem_ren_o, vram_address_o, vram_wdata_o,
           vram_wen_o, SELECT_obm_o, busy_o, done_o
  );

  modport slave (
    output start_i, src_page_i, vblank_i, mem_rdata_i,
    input  mem_address_o, mem_ren_o, vram_address_o, vram_wdata_o,
           vram_wen_o, SELECT_obm_o, busy_o, done_o
  );
endinterface

// File: rtl/obm_dma.sv
// OBM DMA: copies one 256-byte page from CPU memory into object memory during vblank,
// alternating one read cycle and one write cycle per byte.
module obm_dma #(
  parameter int          NUM_BYTES = 256,
  parameter logic [11:0] OBM_BASE  = 12'h800
) (
  input  logic      cpu_clk,
  input  logic      rst_n,
  obm_dma_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VBLANK,
    READ,
    WRITE,
    FINISH
  } state_t;

  localparam logic [7:0] LAST_INDEX = 8'(NUM_BYTES - 1);

  state_t                   state_q, state_d;
  logic [7:0]               page_q, page_d;
  logic [7:0]               index_q, index_d;
  logic                     vramWen_q, vramWen_d;
  mapache64::vram_address_t vramAddr_q, vramAddr_d;
  mapache64::data_t         vramData_q, vramData_d;

  // Write strobes are registered so they hold steady across the negedge where OBM samples.
  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      page_q     <= 8'h00;
      index_q    <= 8'h00;
      vramWen_q  <= 1'b0;
      vramAddr_q <= '0;
      vramData_q <= '0;
    end else begin
      state_q    <= state_d;
      page_q     <= page_d;
      index_q    <= index_d;
      vramWen_q  <= vramWen_d;
      vramAddr_q <= vramAddr_d;
      vramData_q <= vramData_d;
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    index_d = index_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          page_d  = bus.src_page_i;
          index_d = 8'h00;
          state_d = bus.vblank_i ? READ : WAIT_VBLANK;
        end
      end
      WAIT_VBLANK: begin
        if (bus.vblank_i) state_d = READ;
      end
      READ: begin
        // Losing vblank here parks the engine between bytes, before any read is issued.
        state_d = bus.vblank_i ? WRITE : WAIT_VBLANK;
      end
      WRITE: begin
        if (index_q == LAST_INDEX) begin
          state_d = FINISH;
        end else begin
          index_d = index_q + 8'd1;
          state_d = READ;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_ren_o     = 1'b0;
    bus.mem_address_o = 16'h0000;
    bus.busy_o        = (state_q != IDLE);
    bus.done_o        = (state_q == FINISH);
    vramWen_d         = 1'b0;
    vramAddr_d        = '0;
    vramData_d        = '0;
    if (state_q == READ && bus.vblank_i) begin
      bus.mem_ren_o     = 1'b1;
      bus.mem_address_o = {page_q, index_q};
    end
    if (state_q == WRITE) begin
      vramWen_d  = 1'b1;
      vramAddr_d = OBM_BASE + {4'h0, index_q};
      vramData_d = bus.mem_rdata_i;
    end
  end

  assign bus.vram_wen_o     = vramWen_q;
  assign bus.SELECT_obm_o   = vramWen_q;
  assign bus.vram_address_o = vramAddr_q;
  assign bus.vram_wdata_o   = vramData_q;

endmodule

// File: tb/tb_obm_dma.sv
// Self-checking bench for obm_dma: a cycle-by-cycle vector table for the start of a
// transfer, then directed full-transfer sequences with a write/read protocol monitor.
module tb_obm_dma;

  logic cpu_clk = 1'b0;
  logic rst_n   = 1'b0;
  obm_dma_if bus ();

  obm_dma #(.NUM_BYTES(256), .OBM_BASE(12'h800)) dut (
    .cpu_clk (cpu_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 cpu_clk = ~cpu_clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  srcMem [65536];
  logic [7:0]  obm [256];
  int          writesPerAddr [256];
  int          writeCount = 0;
  int          doneCount = 0;
  logic [11:0] firstWriteAddr = 12'h000;
  logic        renH1, renH2;
  logic [15:0] addrH1, addrH2;

  typedef struct {
    logic        start;
    logic [7:0]  page;
    logic        vblank;
    logic        expRen;
    logic [15:0] expMemAddr;
    logic        expWen;
    logic [11:0] expVaddr;
    logic [7:0]  expWdata;
    logic        expBusy;
    logic        expDone;
  } vec_t;

  vec_t vecs [12];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle: inputs change just after the negedge, outputs are then sampled 1 ns later.
  task automatic applyStimulus(input logic start, input logic [7:0] page, input logic vblank);
    @(negedge cpu_clk);
    #1;
    bus.start_i    = start;
    bus.src_page_i = page;
    bus.vblank_i   = vblank;
    #1;
  endtask

  // Source memory answers one cycle after the read strobe.
  always @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_rdata_i <= 8'h00;
      renH1 <= 1'b0; renH2 <= 1'b0;
      addrH1 <= 16'h0; addrH2 <= 16'h0;
    end else begin
      bus.mem_rdata_i <= bus.mem_ren_o ? srcMem[bus.mem_address_o] : 8'h00;
      renH1 <= bus.mem_ren_o;  renH2 <= renH1;
      addrH1 <= bus.mem_address_o; addrH2 <= addrH1;
    end
  end

  // OBM capture and protocol monitor on the write-sampling edge.
  always @(negedge cpu_clk) begin
    checkOutput("selectEqWen", {31'b0, bus.SELECT_obm_o}, {31'b0, bus.vram_wen_o});
    if (bus.vram_wen_o) begin
      checkOutput("renTwoBefore", {31'b0, renH2}, 32'd1);
      checkOutput("writeIndex", {24'b0, bus.vram_address_o[7:0]}, {24'b0, addrH2[7:0]});
      checkOutput("vaddrRange", {28'b0, bus.vram_address_o[11:8]}, 32'h8);
      if (writeCount == 0) firstWriteAddr = bus.vram_address_o;
      obm[bus.vram_address_o[7:0]] = bus.vram_wdata_o;
      writesPerAddr[bus.vram_address_o[7:0]]++;
      writeCount++;
    end
    if (bus.done_o) doneCount++;
  end

  task automatic clearScoreboard();
    for (int i = 0; i < 256; i++) begin
      obm[i] = 8'h00;
      writesPerAddr[i] = 0;
    end
    writeCount = 0;
    doneCount  = 0;
    firstWriteAddr = 12'h000;
  endtask

  task automatic checkCopy(input string name, input logic [7:0] xorKey);
    int bad = 0;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] expByte = 8'(i) ^ xorKey;
      if (obm[i] !== expByte || writesPerAddr[i] != 1) bad++;
    end
    checkOutput(name, bad, 0);
  endtask

  task automatic waitDone(input int budget, output logic seen);
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      if (bus.done_o) seen = 1'b1;
    end
  endtask

  task automatic resetDut();
    @(negedge cpu_clk);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge cpu_clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int   cyc;
    int   busyLow;
    int   activity;
    int   snap;
    logic seen;

    for (int i = 0; i < 256; i++) begin
      srcMem[16'h0200 + i] = 8'(i) ^ 8'h5A;
      srcMem[16'h0700 + i] = 8'(i) ^ 8'hA5;
    end
    bus.start_i = 1'b0; bus.src_page_i = 8'h00; bus.vblank_i = 1'b0;
    clearScoreboard();

    //            start page   vb   ren  memAddr   wen  vaddr   wdata  busy done
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h02, 1'b0, 1'b0, 16'h0000, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 16'h0200, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 16'h0201, 1'b1, 12'h800, 8'h5A, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1, 12'h801, 8'h5B, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 8'h07, 1'b0, 1'b0, 16'h0000, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 16'h0202, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0};

    #1;
    checkOutput("resetBusy", {31'b0, bus.busy_o}, 32'd0);
    checkOutput("resetWen", {31'b0, bus.vram_wen_o}, 32'd0);
    checkOutput("resetVaddr", {20'b0, bus.vram_address_o}, 32'd0);
    @(negedge cpu_clk);
    #1 rst_n = 1'b1;

    for (int v = 0; v < 12; v++) begin
      applyStimulus(vecs[v].start, vecs[v].page, vecs[v].vblank);
      checkOutput($sformatf("vec%0d.ren", v), {31'b0, bus.mem_ren_o}, {31'b0, vecs[v].expRen});
      checkOutput($sformatf("vec%0d.memAddr", v), {16'b0, bus.mem_address_o}, {16'b0, vecs[v].expMemAddr});
      checkOutput($sformatf("vec%0d.wen", v), {31'b0, bus.vram_wen_o}, {31'b0, vecs[v].expWen});
      checkOutput($sformatf("vec%0d.vaddr", v), {20'b0, bus.vram_address_o}, {20'b0, vecs[v].expVaddr});
      checkOutput($sformatf("vec%0d.wdata", v), {24'b0, bus.vram_wdata_o}, {24'b0, vecs[v].expWdata});
      checkOutput($sformatf("vec%0d.busy", v), {31'b0, bus.busy_o}, {31'b0, vecs[v].expBusy});
      checkOutput($sformatf("vec%0d.done", v), {31'b0, bus.done_o}, {31'b0, vecs[v].expDone});
    end
    resetDut();

    $display("[TB] basic copy with latency");
    clearScoreboard();
    applyStimulus(1'b1, 8'h02, 1'b1);
    cyc = 0; busyLow = 0; seen = 1'b0;
    while (!seen && cyc < 600) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      cyc++;
      if (!bus.busy_o) busyLow++;
      if (bus.done_o) seen = 1'b1;
    end
    checkOutput("basicDoneSeen", {31'b0, seen}, 32'd1);
    checkOutput("basicLatency", cyc, 513);
    checkOutput("basicBusyHigh", busyLow, 0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("basicIdleAfter", {30'b0, bus.busy_o, bus.done_o}, 32'd0);
    checkOutput("basicDoneCount", doneCount, 1);
    checkCopy("basicCopy", 8'h5A);

    $display("[TB] vblank gating");
    clearScoreboard();
    applyStimulus(1'b1, 8'h02, 1'b0);
    activity = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      if (bus.mem_ren_o || bus.vram_wen_o) activity++;
    end
    checkOutput("gateNoActivity", activity, 0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("gateRisingCycleRen", {31'b0, bus.mem_ren_o}, 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("gateFirstRead", {15'b0, bus.mem_ren_o, bus.mem_address_o}, {15'b0, 1'b1, 16'h0200});
    waitDone(600, seen);
    checkOutput("gateDoneSeen", {31'b0, seen}, 32'd1);
    checkCopy("gateCopy", 8'h5A);

    $display("[TB] mid-transfer pause");
    clearScoreboard();
    applyStimulus(1'b1, 8'h02, 1'b1);
    cyc = 0;
    while (writeCount < 100 && cyc < 600) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      cyc++;
    end
    checkOutput("pauseReached100", {31'b0, writeCount == 100}, 32'd1);
    for (int c = 0; c < 50; c++) applyStimulus(1'b0, 8'h00, 1'b0);
    snap = writeCount;
    checkOutput("pauseWrites100or101", {31'b0, (snap == 100 || snap == 101)}, 32'd1);
    checkOutput("pauseBusy", {31'b0, bus.busy_o}, 32'd1);
    waitDone(600, seen);
    checkOutput("pauseDoneSeen", {31'b0, seen}, 32'd1);
    checkCopy("pauseCopy", 8'h5A);

    $display("[TB] start while busy");
    clearScoreboard();
    applyStimulus(1'b1, 8'h02, 1'b1);
    cyc = 0;
    while (writeCount < 40 && cyc < 600) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      cyc++;
    end
    applyStimulus(1'b1, 8'h07, 1'b1);
    waitDone(600, seen);
    checkOutput("busyStartDoneSeen", {31'b0, seen}, 32'd1);
    for (int c = 0; c < 5; c++) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("busyStartDoneCount", doneCount, 1);
    checkOutput("busyStartIdle", {31'b0, bus.busy_o}, 32'd0);
    checkCopy("busyStartCopy", 8'h5A);

    $display("[TB] reset mid-transfer");
    clearScoreboard();
    applyStimulus(1'b1, 8'h02, 1'b1);
    cyc = 0;
    while (writeCount < 128 && cyc < 600) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      cyc++;
    end
    checkOutput("resetMidReached128", {31'b0, writeCount == 128}, 32'd1);
    @(negedge cpu_clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("resetMidOutputsZero",
                {bus.mem_ren_o, bus.vram_wen_o, bus.SELECT_obm_o, bus.busy_o, bus.done_o,
                 |bus.mem_address_o, |bus.vram_address_o, |bus.vram_wdata_o}, 32'd0);
    repeat (2) @(negedge cpu_clk);
    #1 rst_n = 1'b1;
    snap = writeCount;
    for (int c = 0; c < 40; c++) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("resetNoResume", writeCount - snap, 0);
    checkOutput("resetStaysIdle", {31'b0, bus.busy_o}, 32'd0);
    clearScoreboard();
    applyStimulus(1'b1, 8'h02, 1'b1);
    waitDone(600, seen);
    checkOutput("recopyDoneSeen", {31'b0, seen}, 32'd1);
    checkOutput("recopyFirstAddr", {20'b0, firstWriteAddr}, 32'h800);
    checkCopy("recopyCopy", 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
